// File: rtl/board_scrambler.sv
// Puzzle-board scrambler: walks a free-running Galois LFSR to pick row/column
// toggle moves and strobes them one at a time toward the cell array.
module board_scrambler #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int          GAP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic [5:0]  move_count,
  output logic [3:0]  row,
  output logic [3:0]  col,
  output logic        fire,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FIRE,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [7:0]  GAP_LAST  = 8'(GAP - 1);

  state_t      state, next_state;
  logic [15:0] lfsr, next_lfsr;
  logic [5:0]  remaining, next_remaining;
  logic [7:0]  gap_cnt, next_gap_cnt;
  logic [2:0]  prev_move, next_prev_move;
  logic        prev_valid, next_prev_valid;
  logic [3:0]  next_row, next_col;
  logic        next_fire, next_done;
  logic [1:0]  pick_idx;
  logic [3:0]  pick_onehot;

  // A zero seed would lock the LFSR, so it falls back to SEED.
  always_comb begin
    if (seed_load) begin
      next_lfsr = (seed == 16'h0000) ? SEED : seed;
    end else if (lfsr[0]) begin
      next_lfsr = (lfsr >> 1) ^ LFSR_MASK;
    end else begin
      next_lfsr = lfsr >> 1;
    end
  end

  // Bump the index when the draw would undo the move just made.
  always_comb begin
    pick_idx = lfsr[1:0];
    if (state == ST_GAP && prev_valid && prev_move == lfsr[2:0]) begin
      pick_idx = lfsr[1:0] + 2'd1;
    end
    pick_onehot = 4'b0001 << pick_idx;
  end

  always_comb begin
    next_state      = state;
    next_remaining  = remaining;
    next_gap_cnt    = gap_cnt;
    next_prev_move  = prev_move;
    next_prev_valid = prev_valid;
    next_row        = row;
    next_col        = col;
    next_fire       = 1'b0;
    next_done       = 1'b0;

    case (state)
      ST_IDLE: begin
        next_prev_valid = 1'b0;
        next_row        = 4'b0000;
        next_col        = 4'b0000;
        if (start && !abort) begin
          if (move_count != 6'd0) begin
            next_state      = ST_SETUP;
            next_remaining  = move_count;
            next_prev_valid = 1'b1;
            next_prev_move  = {lfsr[2], pick_idx};
            next_row        = lfsr[2] ? 4'b0000 : pick_onehot;
            next_col        = lfsr[2] ? pick_onehot : 4'b0000;
          end else begin
            next_state = ST_DONE;
            next_done  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        next_state = ST_FIRE;
        next_fire  = 1'b1;
      end
      ST_FIRE: begin
        next_state = ST_HOLD;
      end
      ST_HOLD: begin
        next_state     = ST_GAP;
        next_remaining = remaining - 6'd1;
        next_gap_cnt   = GAP_LAST;
        next_row       = 4'b0000;
        next_col       = 4'b0000;
      end
      ST_GAP: begin
        if (gap_cnt != 8'd0) begin
          next_gap_cnt = gap_cnt - 8'd1;
        end else if (remaining != 6'd0) begin
          next_state      = ST_SETUP;
          next_prev_valid = 1'b1;
          next_prev_move  = {lfsr[2], pick_idx};
          next_row        = lfsr[2] ? 4'b0000 : pick_onehot;
          next_col        = lfsr[2] ? pick_onehot : 4'b0000;
        end else begin
          next_state = ST_DONE;
          next_done  = 1'b1;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
        next_row   = 4'b0000;
        next_col   = 4'b0000;
      end
    endcase

    if (abort && state != ST_IDLE) begin
      next_state      = ST_IDLE;
      next_remaining  = 6'd0;
      next_prev_valid = 1'b0;
      next_row        = 4'b0000;
      next_col        = 4'b0000;
      next_fire       = 1'b0;
      next_done       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      lfsr       <= SEED;
      remaining  <= 6'd0;
      gap_cnt    <= 8'd0;
      prev_move  <= 3'd0;
      prev_valid <= 1'b0;
      row        <= 4'b0000;
      col        <= 4'b0000;
      fire       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      lfsr       <= next_lfsr;
      remaining  <= next_remaining;
      gap_cnt    <= next_gap_cnt;
      prev_move  <= next_prev_move;
      prev_valid <= next_prev_valid;
      row        <= next_row;
      col        <= next_col;
      fire       <= next_fire;
      done       <= next_done;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_board_scrambler.sv
// Randomized self-checking bench for board_scrambler against a move-level
// reference model built from the LFSR rule and the per-move cycle budget.
module tb_board_scrambler;

  localparam logic [15:0] SEED_REF = 16'hACE1;
  localparam int          GAP_REF  = 4;
  localparam int          PERIOD   = GAP_REF + 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        seed_load;
  logic [15:0] seed;
  logic [5:0]  move_count;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        fire;
  logic        busy;
  logic        done;

  int          total;
  int          bad;
  logic [15:0] m_lfsr;
  logic [7:0]  first_rc;
  logic [7:0]  reset_rc;

  board_scrambler #(.SEED(SEED_REF), .GAP(GAP_REF)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .seed_load  (seed_load),
    .seed       (seed),
    .move_count (move_count),
    .row        (row),
    .col        (col),
    .fire       (fire),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: the reference LFSR follows whatever seed_load/seed the edge sees.
  task automatic tick();
    logic        sl;
    logic [15:0] sd;
    sl = seed_load;
    sd = seed;
    @(posedge clk);
    if (sl) m_lfsr = (sd == 16'h0000) ? SEED_REF : sd;
    else    m_lfsr = lfsr_step(m_lfsr);
    #1;
  endtask

  // Runs one scramble of n moves, checking every cycle until done (or abort).
  task automatic applyStimulus(input int n, input int abort_at, input bit poke);
    logic [2:0]  mv[$];
    logic [2:0]  m;
    logic [2:0]  prev;
    logic [15:0] lf;
    logic [3:0]  oh;
    logic [7:0]  exp_rc;
    logic [7:0]  prev_obs;
    bit          have_prev;
    bit          exp_fire;
    int          last;
    int          k;
    int          phase;
    int          fires;

    lf        = m_lfsr;
    prev      = 3'd0;
    have_prev = 1'b0;
    prev_obs  = 8'd0;
    fires     = 0;
    for (int i = 0; i < n; i++) begin
      m = lf[2:0];
      if (i > 0 && m == prev) m[1:0] = m[1:0] + 2'd1;
      mv.push_back(m);
      prev = m;
      for (int j = 0; j < PERIOD; j++) lf = lfsr_step(lf);
    end

    start      = 1'b1;
    move_count = 6'(n);
    tick();
    start = 1'b0;
    last  = n * PERIOD + 1;

    for (int off = 1; off <= last; off++) begin
      k        = (off - 1) / PERIOD;
      phase    = (off - 1) % PERIOD;
      exp_fire = (off < last) && (phase == 1);
      exp_rc   = 8'd0;
      if (off < last && phase < 3) begin
        oh     = 4'b0001 << mv[k][1:0];
        exp_rc = mv[k][2] ? {4'b0000, oh} : {oh, 4'b0000};
      end
      checkOutput("fire", 32'(fire), 32'(exp_fire));
      checkOutput("rowcol", 32'({row, col}), 32'(exp_rc));
      checkOutput("done", 32'(done), 32'(off == last));
      checkOutput("busy", 32'(busy), 32'd1);
      if (fire) begin
        fires++;
        if (fires == 1) first_rc = {row, col};
        if (have_prev) checkOutput("no_repeat", 32'({row, col} != prev_obs), 32'd1);
        prev_obs  = {row, col};
        have_prev = 1'b1;
      end
      if (abort_at != 0 && fires == abort_at && fire) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_out", 32'({row, col, fire, done}), 32'd0);
        for (int j = 0; j < 10; j++) begin
          tick();
          checkOutput("abort_quiet", 32'({fire, done}), 32'd0);
        end
        break;
      end
      if (off != last) begin
        start = poke && (off == 3);
        if (start) move_count = 6'd5;
        tick();
        start = 1'b0;
      end
    end

    checkOutput("fire_count", 32'(fires), 32'((abort_at != 0) ? abort_at : n));
    if (abort_at == 0) begin
      tick();
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    seed_load  = 1'b0;
    seed       = 16'h0000;
    move_count = 6'd0;
    m_lfsr     = SEED_REF;
    first_rc   = 8'd0;

    repeat (2) @(posedge clk);
    #3;
    checkOutput("reset_out", 32'({row, col, fire, busy, done}), 32'd0);
    reset  = 1'b0;
    m_lfsr = SEED_REF;

    applyStimulus(1, 0, 0);
    reset_rc = first_rc;

    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle_hold", 32'(busy), 32'd0);
    end

    seed_load = 1'b1;
    seed      = 16'h0000;
    tick();
    seed_load = 1'b0;
    applyStimulus(1, 0, 0);
    checkOutput("seed_zero_move", 32'(first_rc), 32'(reset_rc));

    applyStimulus(63, 0, 0);
    applyStimulus(5, 3, 0);
    applyStimulus(2, 0, 1);
    applyStimulus(0, 0, 0);

    abort = 1'b1;
    start = 1'b1;
    move_count = 6'd3;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_wins", 32'(busy), 32'd0);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        seed      = 16'($urandom);
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(int'($urandom_range(1, 6)), 0, 0);
    end

    // Reset lands between edges while the scramble sits in its gap.
    move_count = 6'd2;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_out", 32'({row, col, fire, busy, done}), 32'd0);
    @(posedge clk);
    #3;
    reset  = 1'b0;
    m_lfsr = SEED_REF;
    applyStimulus(1, 0, 0);
    checkOutput("reset_lfsr_move", 32'(first_rc), 32'(reset_rc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_scrambler.md
BOARD_SCRAMBLER -- requirements
Module: board_scrambler

Interface
REQ-001 The block SHALL have parameter SEED, default 16'hACE1, which is the LFSR value after reset.
REQ-002 The block SHALL have parameter GAP, default 4, which is the number of idle cycles between moves (legal range 1-255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: level request to begin a scramble; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous cancel of a running scramble.
REQ-007 The block SHALL have port seed_load, input, 1 bit: one-cycle strobe that loads seed into the LFSR.
REQ-008 The block SHALL have port seed, input, 16 bits: the new LFSR value; 16'h0000 is replaced by SEED.
REQ-009 The block SHALL have port move_count, input, 6 bits: the number of moves, sampled on start.
REQ-010 The block SHALL have port row, output, 4 bits: one-hot row select toward the cell array.
REQ-011 The block SHALL have port col, output, 4 bits: one-hot column select toward the cell array.
REQ-012 The block SHALL have port fire, output, 1 bit: one-cycle toggle strobe.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when a scramble completes.

Function
REQ-015 The LFSR SHALL be a 16-bit Galois LFSR with mask 16'hB400, and SHALL advance every clock in every state.
REQ-016 When seed_load is high, the LFSR SHALL take seed on that clock edge instead of advancing.
REQ-017 The FSM SHALL have the states IDLE, SETUP, FIRE, HOLD, GAP and DONE.
REQ-018 In IDLE, start=1 with move_count!=0 SHALL load the remaining-moves counter with move_count and go to SETUP.
REQ-019 In IDLE, start=1 with move_count=0 SHALL go to DONE directly, with no row, col or fire activity.
REQ-020 On entry to SETUP, lfsr[2] SHALL select row (0) or column (1), and lfsr[1:0] SHALL select the index.
REQ-021 If the selected move equals the previous move of the same scramble, the index SHALL be incremented mod 4, so a move never immediately cancels itself.
REQ-022 In SETUP, exactly one bit of row or of col SHALL be driven, and the other bus SHALL be 4'b0000.
REQ-023 SETUP SHALL last 1 cycle, then go to FIRE.
REQ-024 FIRE SHALL last 1 cycle with fire=1 and row/col unchanged.
REQ-025 HOLD SHALL last 1 cycle with fire=0 and row/col unchanged, and SHALL decrement the remaining-moves counter.
REQ-026 In GAP, row=col=0 and fire=0 for GAP cycles.
REQ-027 At the end of GAP, the FSM SHALL go to SETUP if remaining!=0, otherwise to DONE.
REQ-028 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-029 Each move SHALL take 3+GAP cycles, and a scramble of N moves SHALL take N*(3+GAP)+1 cycles from the start sample to the done pulse.
REQ-030 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-031 start held high through DONE SHALL begin a new scramble on the first IDLE cycle.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear row, col and fire, produce no done pulse, and leave the LFSR running.
REQ-033 If abort and start are asserted in IDLE on the same cycle, abort SHALL win and no scramble SHALL begin.
REQ-034 fire SHALL never be asserted while both row and col are zero, nor while both are non-zero.
REQ-035 row, col, fire and done SHALL be registered outputs.
REQ-036 The previous-move record SHALL be cleared at the start of each scramble.

Reset
REQ-037 While reset=1, the block SHALL asynchronously set: state IDLE, row=0, col=0, fire=0, busy=0, done=0, remaining=0, previous-move cleared, LFSR=SEED.
REQ-038 Reset asserted mid-scramble SHALL abandon the scramble immediately, with no further fire pulses and no done pulse.
REQ-039 After reset deasserts, the first state change SHALL occur on the first clk edge where start=1.

Verification
REQ-040 The bench SHALL cover: reset; start with move_count=1, GAP=4 -> fire pulse 2 cycles after the start sample with one-hot select matching lfsr[2:0]; done 8 cycles after the start sample.
REQ-041 The bench SHALL cover: seed_load with 16'h0000, then start -> same move sequence as immediately after reset (SEED substitution).
REQ-042 The bench SHALL cover: move_count=63 -> exactly 63 fire pulses; no two consecutive moves identical; row/col one-hot at every fire; done at cycle 63*7+1.
REQ-043 The bench SHALL cover: abort during the third move's FIRE state -> next cycle IDLE with row=col=fire=0, no done pulse, fire count 3.
REQ-044 The bench SHALL cover: start pulsed while busy, and start with move_count=0 -> the first is ignored; the second gives done the cycle after the start sample with no fire.
REQ-045 The bench SHALL cover: reset asserted asynchronously mid-GAP (between clock edges) -> outputs clear immediately, before the next clk edge; LFSR=16'hACE1.
